// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
// Default STABLE_CYCLES gives a 10 ms window on the 100 MHz board clock.
package debounce_pkg;

    localparam int CLK_HZ            = 100_000_000;
    localparam int DEBOUNCE_MS       = 10;
    localparam int DEF_STABLE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int DEF_LONG_CYCLES   = CLK_HZ;

    // Bits needed to hold the values 0..n
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, stability counter, clean level, strobes.
// DEBOUNCE_LONG_PRESS_EN adds a per-channel hold counter and long-press strobe.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int SYNC_STAGES   = 2,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync;
    logic                   flip;

    assign sync = sync_q[SYNC_STAGES-1];
    assign flip = (sync != clean_q) && (cnt_q == CNT_LAST);

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d   = cnt_q + 1'b1;
        clean_d = clean_q;
        rise_d  = flip & sync;
        fall_d  = flip & ~sync;
        // Any bounce back to the clean level restarts the window
        if (sync == clean_q || flip) begin
            cnt_d = '0;
        end
        if (flip) begin
            clean_d = sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int HW = cnt_width(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Saturating past the fire point gives one strobe per press
    always_comb begin
        hold_d = '0;
        long_d = 1'b0;
        if (clean_q) begin
            hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
            long_d = (hold_q == HOLD_FIRE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0 & (LONG_CYCLES > 0);
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: CHANNELS independent debounce_chan copies.
// Define DEBOUNCE_LONG_PRESS_EN to enable the long-press strobes.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int SYNC_STAGES   = 2,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] bouncey_in,
    output logic [CHANNELS-1:0] clean_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] long_press
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .LONG_CYCLES   (LONG_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .din        (bouncey_in[i]),
            .clean      (clean_out[i]),
            .rise       (rise_pulse[i]),
            .fall       (fall_pulse[i]),
            .long_press (long_press[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi (16-cycle window, 2 sync stages).
// Long-press checks follow DEBOUNCE_LONG_PRESS_EN.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] bouncey_in = 4'h0;
    logic [3:0] clean_out, rise_pulse, fall_pulse, long_press;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    debounce_multi #(
        .CHANNELS      (4),
        .STABLE_CYCLES (16),
        .SYNC_STAGES   (2),
        .LONG_CYCLES   (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bouncey_in (bouncey_in),
        .clean_out  (clean_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .long_press (long_press)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] v);
        @(negedge clk);
        rst_n = 1'b0;
        bouncey_in = v;
        tick(3);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset(4'hF);
        rst_n = 1'b0;
        tick(2);
        n_chk++;
        if ({clean_out, rise_pulse, fall_pulse, long_press} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h required 0000",
                     {clean_out, rise_pulse, fall_pulse, long_press});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(17);
        n_chk++;
        if (clean_out !== 4'h0 || rise_pulse !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_early: clean %h rise %h required 0 0",
                     clean_out, rise_pulse);
        end
        tick(1);
        n_chk++;
        if (clean_out !== 4'hF || rise_pulse !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_rise: clean %h rise %h required F F",
                     clean_out, rise_pulse);
        end
        tick(1);
        n_chk++;
        if (clean_out !== 4'hF || rise_pulse !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_rise_end: clean %h rise %h required F 0",
                     clean_out, rise_pulse);
        end
    endtask

    task automatic test_bounce;
        do_reset(4'h0);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            bouncey_in[0] = (c % 5 == 0);
            tick(1);
            n_chk++;
            if (clean_out !== 4'h0 || rise_pulse !== 4'h0 || fall_pulse !== 4'h0) begin
                n_fail++;
                $display("FAIL bounce c%0d: clean %h rise %h fall %h required 0 0 0",
                         c, clean_out, rise_pulse, fall_pulse);
            end
        end
        @(negedge clk);
        bouncey_in = 4'h0;
    endtask

    task automatic test_press;
        do_reset(4'h0);
        @(negedge clk);
        bouncey_in[1] = 1'b1;
        tick(17);
        n_chk++;
        if (clean_out !== 4'h0) begin
            n_fail++;
            $display("FAIL press_early: clean %h required 0", clean_out);
        end
        tick(1);
        n_chk++;
        if (clean_out !== 4'h2 || rise_pulse !== 4'h2 || fall_pulse !== 4'h0) begin
            n_fail++;
            $display("FAIL press_rise: clean %h rise %h fall %h required 2 2 0",
                     clean_out, rise_pulse, fall_pulse);
        end
        tick(1);
        n_chk++;
        if (clean_out !== 4'h2 || rise_pulse !== 4'h0) begin
            n_fail++;
            $display("FAIL press_rise_end: clean %h rise %h required 2 0",
                     clean_out, rise_pulse);
        end
        @(negedge clk);
        bouncey_in[1] = 1'b0;
        tick(17);
        n_chk++;
        if (clean_out !== 4'h2 || fall_pulse !== 4'h0) begin
            n_fail++;
            $display("FAIL release_early: clean %h fall %h required 2 0",
                     clean_out, fall_pulse);
        end
        tick(1);
        n_chk++;
        if (clean_out !== 4'h0 || fall_pulse !== 4'h2 || rise_pulse !== 4'h0) begin
            n_fail++;
            $display("FAIL release_fall: clean %h fall %h rise %h required 0 2 0",
                     clean_out, fall_pulse, rise_pulse);
        end
        tick(1);
        n_chk++;
        if (fall_pulse !== 4'h0) begin
            n_fail++;
            $display("FAIL release_fall_end: fall %h required 0", fall_pulse);
        end
    endtask

    task automatic test_boundary;
        do_reset(4'h0);
        @(negedge clk);
        bouncey_in[2] = 1'b1;
        tick(15);
        @(negedge clk);
        bouncey_in[2] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            n_chk++;
            if (clean_out !== 4'h0 || rise_pulse !== 4'h0) begin
                n_fail++;
                $display("FAIL short15 c%0d: clean %h rise %h required 0 0",
                         c, clean_out, rise_pulse);
            end
        end
        @(negedge clk);
        bouncey_in[2] = 1'b1;
        tick(16);
        @(negedge clk);
        bouncey_in[2] = 1'b0;
        tick(1);
        n_chk++;
        if (clean_out !== 4'h0) begin
            n_fail++;
            $display("FAIL hold16_early: clean %h required 0", clean_out);
        end
        tick(1);
        n_chk++;
        if (clean_out !== 4'h4 || rise_pulse !== 4'h4) begin
            n_fail++;
            $display("FAIL hold16_rise: clean %h rise %h required 4 4",
                     clean_out, rise_pulse);
        end
    endtask

    task automatic test_simultaneous;
        do_reset(4'h0);
        @(negedge clk);
        bouncey_in = 4'h9;
        tick(17);
        n_chk++;
        if (rise_pulse !== 4'h0) begin
            n_fail++;
            $display("FAIL simul_early: rise %h required 0", rise_pulse);
        end
        tick(1);
        n_chk++;
        if (clean_out !== 4'h9 || rise_pulse !== 4'h9) begin
            n_fail++;
            $display("FAIL simul_rise: clean %h rise %h required 9 9",
                     clean_out, rise_pulse);
        end
        tick(1);
        n_chk++;
        if (rise_pulse !== 4'h0) begin
            n_fail++;
            $display("FAIL simul_rise_end: rise %h required 0", rise_pulse);
        end
        @(negedge clk);
        bouncey_in = 4'h0;
        tick(10);
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({clean_out, rise_pulse, fall_pulse} !== 12'h0) begin
            n_fail++;
            $display("FAIL async_rst: got %h required 000",
                     {clean_out, rise_pulse, fall_pulse});
        end
        #1 rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            n_chk++;
            if ({clean_out, rise_pulse, fall_pulse} !== 12'h0) begin
                n_fail++;
                $display("FAIL post_rst c%0d: got %h required 000",
                         c, {clean_out, rise_pulse, fall_pulse});
            end
        end
    endtask

    task automatic test_long_press;
        logic [3:0] exp;
        do_reset(4'h0);
        @(negedge clk);
        bouncey_in[1] = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            tick(1);
`ifdef DEBOUNCE_LONG_PRESS_EN
            exp = (c == 18 + 64) ? 4'h2 : 4'h0;
`else
            exp = 4'h0;
`endif
            n_chk++;
            if (long_press !== exp) begin
                n_fail++;
                $display("FAIL long_press c%0d: got %h required %h",
                         c, long_press, exp);
            end
        end
        @(negedge clk);
        bouncey_in = 4'h0;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_press();
        test_boundary();
        test_simultaneous();
        test_long_press();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
